modulo_varredura_matriz: RTL and testbench
==========================================

MODULO_VARREDURA_MATRIZ -- requirements
Module: modulo_varredura_matriz

Interface
REQ-001 Parameter DWELL, default 1000, SHALL set the number of clock cycles each row is lit (legal range 1..65535).
REQ-002 Parameter BLANK, default 4, SHALL set the number of dark cycles between rows (legal range 1..255).
REQ-003 Parameter NUM_ROWS, default 7, SHALL set the number of rows scanned per frame (legal range 2..7).
REQ-004 Block SHALL use one clock and synchronous, active-high reset: port clk (input, 1) and port reset (input, 1).
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 enable  input  1  scanning permitted while high.
REQ-008 data_ack  input  1  col_data valid for the requested row.
REQ-009 col_data  input  5  column pattern for row_idx.
REQ-010 row_idx  output  3  current row index, feeds the row-coordinate decoder.
REQ-011 data_req  output  1  request column pattern for row_idx.
REQ-012 row_sel  output  7  one-hot active-high row drive, bit k = row k.
REQ-013 col_out  output  5  latched column drive.
REQ-014 frame_done  output  1  one-cycle pulse at end of frame.

Function
REQ-015 All outputs SHALL be registered, and the FSM SHALL have exactly four states: IDLE, REQ, SHOW, BLANK.
REQ-016 IDLE: row_sel=0, col_out=0, data_req=0, row_idx=0; enable=1 SHALL move the FSM to REQ on the next edge.
REQ-017 REQ: data_req=1, row_sel=0, col_out=0; data_ack=1 SHALL latch col_data into col_out, load the dwell counter with DWELL-1, and enter SHOW on the next edge.
REQ-018 REQ with data_ack=0 SHALL hold indefinitely, with no timeout and row_idx stable.
REQ-019 data_ack SHALL be sampled only in REQ; acknowledgements in IDLE, SHOW or BLANK SHALL be ignored.
REQ-020 SHOW: row_sel=one-hot(row_idx), col_out held, data_req=0; the counter SHALL decrement each cycle, and at 0 the FSM SHALL enter BLANK with the counter loaded to BLANK-1.
REQ-021 SHOW SHALL last exactly DWELL cycles.
REQ-022 BLANK: row_sel=0, col_out=0; the counter SHALL decrement each cycle, and BLANK SHALL last exactly BLANK cycles.
REQ-023 End of BLANK with row_idx<NUM_ROWS-1: row_idx SHALL increment by 1.
REQ-024 End of BLANK with row_idx=NUM_ROWS-1: row_idx SHALL wrap to 0, and frame_done SHALL be 1 for exactly the following cycle.
REQ-025 End of BLANK: next state SHALL be REQ if enable=1, else IDLE with row_idx forced to 0.
REQ-026 enable SHALL be sampled only in IDLE and at the last BLANK cycle; deassertion during REQ or SHOW SHALL complete the current row, including its blank.
REQ-027 Deassertion mid-frame SHALL NOT assert frame_done.
REQ-028 At most one row_sel bit SHALL be high in any cycle.
REQ-029 row_sel SHALL be 0 in every cycle where col_out changes.
REQ-030 Latency: enable rising in IDLE at cycle n SHALL give data_req=1 at n+1.
REQ-031 Latency: data_ack at cycle m SHALL give row_sel/col_out valid at m+1.
REQ-032 Dwell and blank counters SHALL be 16 bits wide and SHALL never underflow.

Reset
REQ-033 reset=1 at a clock edge SHALL force state=IDLE, row_idx=0, row_sel=0, col_out=0, data_req=0, frame_done=0 and counters=0, regardless of state.
REQ-034 Reset SHALL take priority over enable and data_ack.
REQ-035 Reset asserted mid-SHOW SHALL blank the row on the next edge.
REQ-036 After reset release with enable=1, the FSM SHALL enter REQ for row 0 one cycle later.

Verification (DWELL=4, BLANK=2, NUM_ROWS=7)
REQ-037 Reset, then enable=1 at cycle 0, data_ack=1 with col_data=10101 at cycle 1 -> row_sel=0000001 and col_out=10101 at cycles 2-5, both 0 at cycles 6-7, data_req=1 with row_idx=1 at cycle 8.
REQ-038 Full frame with immediate acks -> rows 0..6 lit in order, frame_done=1 for one cycle after row 6 blank, row_idx=0, next REQ follows.
REQ-039 Hold data_ack=0 for 20 cycles in REQ -> data_req stays 1, row_sel=0, row_idx unchanged; ack then proceeds normally.
REQ-040 Drop enable during SHOW of row 3 -> row 3 completes its 4 lit and 2 blank cycles, then IDLE with row_idx=0 and no frame_done.
REQ-041 Assert reset during SHOW of row 2 -> next cycle all outputs 0, state IDLE.
REQ-042 Pulse data_ack in SHOW with col_data=11111 -> col_out unchanged.

Source files
------------

// File: rtl/modulo_varredura_matriz.sv
// Row-scan driver for a 7x5 LED matrix: requests each row's column pattern,
// lights the row for DWELL cycles, then blanks it for BLANK cycles before moving on.
module modulo_varredura_matriz #(
    parameter int DWELL    = 1000,
    parameter int BLANK    = 4,
    parameter int NUM_ROWS = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       data_ack,
    input  logic [4:0] col_data,
    output logic [2:0] row_idx,
    output logic       data_req,
    output logic [6:0] row_sel,
    output logic [4:0] col_out,
    output logic       frame_done
);

    localparam logic [15:0] DWELL_LOAD = 16'(DWELL - 1);
    localparam logic [15:0] BLANK_LOAD = 16'(BLANK - 1);
    localparam logic [2:0]  LAST_ROW   = 3'(NUM_ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_SHOW  = 2'd2,
        S_BLANK = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] cnt_reg, cnt_next;
    logic [2:0]  row_idx_reg, row_idx_next;
    logic [6:0]  row_sel_reg, row_sel_next;
    logic [4:0]  col_out_reg, col_out_next;
    logic        data_req_reg, data_req_next;
    logic        frame_done_reg, frame_done_next;
    logic [6:0]  row_hot;
    logic [4:0]  col_hold;

    // Row decoder works on the next-cycle index so row_sel stays a pure register.
    genvar gi;
    generate
        for (gi = 0; gi < 7; gi++) begin : g_row_dec
            assign row_hot[gi] = (row_idx_next == 3'(gi));
        end
    endgenerate

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        row_idx_next    = row_idx_reg;
        frame_done_next = 1'b0;
        col_hold        = col_out_reg;
        case (state_reg)
            S_IDLE: begin
                row_idx_next = 3'd0;
                if (enable) begin
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (data_ack) begin
                    col_hold   = col_data;
                    cnt_next   = DWELL_LOAD;
                    state_next = S_SHOW;
                end
            end
            S_SHOW: begin
                if (cnt_reg == 16'd0) begin
                    cnt_next   = BLANK_LOAD;
                    state_next = S_BLANK;
                end else begin
                    cnt_next = cnt_reg - 16'd1;
                end
            end
            S_BLANK: begin
                if (cnt_reg == 16'd0) begin
                    if (row_idx_reg == LAST_ROW) begin
                        row_idx_next    = 3'd0;
                        frame_done_next = 1'b1;
                    end else begin
                        row_idx_next = row_idx_reg + 3'd1;
                    end
                    if (enable) begin
                        state_next = S_REQ;
                    end else begin
                        state_next   = S_IDLE;
                        row_idx_next = 3'd0;
                    end
                end else begin
                    cnt_next = cnt_reg - 16'd1;
                end
            end
            default: begin
                state_next   = S_IDLE;
                row_idx_next = 3'd0;
            end
        endcase

        data_req_next = (state_next == S_REQ);
        row_sel_next  = (state_next == S_SHOW) ? row_hot : 7'd0;
        col_out_next  = (state_next == S_SHOW) ? col_hold : 5'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= 16'd0;
            row_idx_reg    <= 3'd0;
            row_sel_reg    <= 7'd0;
            col_out_reg    <= 5'd0;
            data_req_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            row_idx_reg    <= row_idx_next;
            row_sel_reg    <= row_sel_next;
            col_out_reg    <= col_out_next;
            data_req_reg   <= data_req_next;
            frame_done_reg <= frame_done_next;
        end
    end

    assign row_idx    = row_idx_reg;
    assign data_req   = data_req_reg;
    assign row_sel    = row_sel_reg;
    assign col_out    = col_out_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_modulo_varredura_matriz.sv
// Bench for modulo_varredura_matriz with DWELL=4, BLANK=2, NUM_ROWS=7: a vector table
// for the first row, then hand-built sequences for hold, frame wrap, enable drop and reset.
module tb_modulo_varredura_matriz;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       data_ack;
    logic [4:0] col_data;
    logic [2:0] row_idx;
    logic       data_req;
    logic [6:0] row_sel;
    logic [4:0] col_out;
    logic       frame_done;

    int checks = 0;
    int errors = 0;

    modulo_varredura_matriz #(
        .DWELL(4),
        .BLANK(2),
        .NUM_ROWS(7)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .data_ack(data_ack),
        .col_data(col_data),
        .row_idx(row_idx),
        .data_req(data_req),
        .row_sel(row_sel),
        .col_out(col_out),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic       en;
        logic       ack;
        logic [4:0] cd;
        logic [2:0] idx;
        logic       req;
        logic [6:0] sel;
        logic [4:0] col;
        logic       fd;
    } vec_t;

    vec_t        vecs [9];
    logic [16:0] exp_q [$];
    string       name_q [$];

    // Inputs for one cycle; the expected outputs are those seen after the next edge.
    task automatic step(input logic r, input logic e, input logic a, input logic [4:0] c,
                        input logic [2:0] xi, input logic xr, input logic [6:0] xs,
                        input logic [4:0] xc, input logic xf, input string nm);
        logic [16:0] got;
        logic [16:0] want;
        string       pname;
        reset    = r;
        enable   = e;
        data_ack = a;
        col_data = c;
        exp_q.push_back({xi, xr, xs, xc, xf});
        name_q.push_back(nm);
        @(posedge clk);
        #1;
        want  = exp_q.pop_front();
        pname = name_q.pop_front();
        got   = {row_idx, data_req, row_sel, col_out, frame_done};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got idx/req/sel/col/fd=%b required %b", pname, got, want);
        end else begin
            $display("ok   %s idx=%0d req=%b sel=%b col=%b fd=%b", pname, row_idx,
                     data_req, row_sel, col_out, frame_done);
        end
    endtask

    // Starting in REQ for row k: ack, 4 lit cycles, 2 blank cycles, then the next row/idle.
    task automatic do_row(input int k, input logic [4:0] cd, input logic en_show,
                          input logic en_last, input logic ack_show);
        logic [6:0] oh;
        logic [2:0] ni;
        logic       nf;
        oh = 7'd1 << k;
        step(1'b0, en_show, 1'b1, cd, 3'(k), 1'b0, oh, cd, 1'b0, $sformatf("row%0d_lit0", k));
        for (int i = 1; i < 4; i++) begin
            step(1'b0, en_show, ack_show, ack_show ? 5'b11111 : cd, 3'(k), 1'b0, oh, cd, 1'b0,
                 $sformatf("row%0d_lit%0d", k, i));
        end
        step(1'b0, en_show, 1'b0, cd, 3'(k), 1'b0, 7'd0, 5'd0, 1'b0, $sformatf("row%0d_blank0", k));
        step(1'b0, en_show, 1'b0, cd, 3'(k), 1'b0, 7'd0, 5'd0, 1'b0, $sformatf("row%0d_blank1", k));
        if (k == 6) begin
            ni = 3'd0;
            nf = 1'b1;
        end else begin
            ni = en_last ? 3'(k + 1) : 3'd0;
            nf = 1'b0;
        end
        step(1'b0, en_last, 1'b0, cd, ni, en_last, 7'd0, 5'd0, nf, $sformatf("row%0d_next", k));
    endtask

    // At most one row may be driven at any time.
    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if ($countones(row_sel) > 1) begin
                errors++;
                $display("FAIL onehot row_sel=%b required at most one bit", row_sel);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        enable   = 1'b0;
        data_ack = 1'b0;
        col_data = 5'd0;

        //            rst   en    ack   cd        idx   req   sel         col       fd
        vecs[0] = '{1'b1, 1'b0, 1'b0, 5'b00000, 3'd0, 1'b0, 7'b0000000, 5'b00000, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 5'b00000, 3'd0, 1'b1, 7'b0000000, 5'b00000, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 5'b10101, 3'd0, 1'b0, 7'b0000001, 5'b10101, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 5'b00000, 3'd0, 1'b0, 7'b0000001, 5'b10101, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 5'b00000, 3'd0, 1'b0, 7'b0000001, 5'b10101, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 5'b00000, 3'd0, 1'b0, 7'b0000001, 5'b10101, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 5'b00000, 3'd0, 1'b0, 7'b0000000, 5'b00000, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 5'b00000, 3'd0, 1'b0, 7'b0000000, 5'b00000, 1'b0};
        vecs[8] = '{1'b0, 1'b1, 1'b0, 5'b00000, 3'd1, 1'b1, 7'b0000000, 5'b00000, 1'b0};

        @(posedge clk);
        #1;
        for (int i = 0; i < 9; i++) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].ack, vecs[i].cd, vecs[i].idx, vecs[i].req,
                 vecs[i].sel, vecs[i].col, vecs[i].fd, $sformatf("vec%0d", i));
        end

        // Row 1 waits in REQ without an ack.
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, 1'b0, 5'b01010, 3'd1, 1'b1, 7'd0, 5'd0, 1'b0,
                 $sformatf("hold%0d", i));
        end

        // Rest of the frame; row 6 wraps with a frame_done pulse.
        do_row(1, 5'b00110, 1'b1, 1'b1, 1'b0);
        do_row(2, 5'b11000, 1'b1, 1'b1, 1'b0);
        do_row(3, 5'b00001, 1'b1, 1'b1, 1'b0);
        do_row(4, 5'b10010, 1'b1, 1'b1, 1'b0);
        do_row(5, 5'b01111, 1'b1, 1'b1, 1'b0);
        do_row(6, 5'b11011, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 5'd0, 3'd0, 1'b1, 7'd0, 5'd0, 1'b0, "frame_done_single");

        // Second frame: acks during SHOW are ignored, enable dropped at row 3.
        do_row(0, 5'b10001, 1'b1, 1'b1, 1'b0);
        do_row(1, 5'b00100, 1'b1, 1'b1, 1'b1);
        do_row(2, 5'b01110, 1'b1, 1'b1, 1'b0);
        do_row(3, 5'b10100, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0, 7'd0, 5'd0, 1'b0, "idle_stays");
        step(1'b0, 1'b0, 1'b1, 5'b11111, 3'd0, 1'b0, 7'd0, 5'd0, 1'b0, "idle_ack_ignored");

        // Reset in the middle of row 2's SHOW.
        step(1'b0, 1'b1, 1'b0, 5'd0, 3'd0, 1'b1, 7'd0, 5'd0, 1'b0, "restart_req");
        do_row(0, 5'b11100, 1'b1, 1'b1, 1'b0);
        do_row(1, 5'b00111, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 5'b01001, 3'd2, 1'b0, 7'b0000100, 5'b01001, 1'b0, "row2_lit0");
        step(1'b0, 1'b1, 1'b0, 5'd0, 3'd2, 1'b0, 7'b0000100, 5'b01001, 1'b0, "row2_lit1");
        step(1'b1, 1'b1, 1'b0, 5'd0, 3'd0, 1'b0, 7'd0, 5'd0, 1'b0, "reset_mid_show");
        step(1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0, 7'd0, 5'd0, 1'b0, "idle_after_reset");

        // Reset wins over enable and ack; release with enable gives REQ row 0.
        step(1'b1, 1'b1, 1'b0, 5'd0, 3'd0, 1'b0, 7'd0, 5'd0, 1'b0, "reset_over_enable");
        step(1'b0, 1'b1, 1'b0, 5'd0, 3'd0, 1'b1, 7'd0, 5'd0, 1'b0, "release_to_req");
        step(1'b1, 1'b1, 1'b1, 5'b11111, 3'd0, 1'b0, 7'd0, 5'd0, 1'b0, "reset_over_ack");
        step(1'b0, 1'b1, 1'b0, 5'd0, 3'd0, 1'b1, 7'd0, 5'd0, 1'b0, "req_again");
        do_row(0, 5'b01010, 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
